// File: rtl/fxp_pkg.sv
// Shared fixed-point definitions: opcode enum and internal-format width helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fxp_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_LOAD = 2'd2,
    OP_ACC  = 2'd3
  } op_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One guard integer bit so an add/sub of two aligned operands never overflows.
  function automatic int fxp_wim(input int wi1, input int wi2, input int wi0);
    return max3(wi1, wi2, wi0) + 1;
  endfunction

  function automatic int fxp_wfm(input int wf1, input int wf2, input int wf0);
    return max3(wf1, wf2, wf0);
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Narrows a signed WII.WFI value to WIO.WFO with optional round-half-up and saturation.
// Latency: combinational.
// Backpressure: none; pure function of din. Expects WFI >= WFO and WII+WFI >= WIO+WFO.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int WII   = 9,
  parameter int WFI   = 8,
  parameter int WIO   = 8,
  parameter int WFO   = 8,
  parameter bit ROUND = 1'b1,
  parameter bit SAT   = 1'b1
) (
  input  logic [WII+WFI-1:0] din,
  output logic [WIO+WFO-1:0] dout,
  output logic               ovf
);

  localparam int WN     = WII + WFI;
  localparam int WO     = WIO + WFO;
  localparam int DROP   = WFI - WFO;
  localparam bit DO_RND = ROUND && (DROP > 0);
  localparam int RPOS   = (DROP > 0) ? DROP - 1 : 0;
  localparam logic [WN:0] RND_INC = (WN+1)'(DO_RND) << RPOS;

  // One extra MSB so the rounding increment can never wrap the value.
  logic signed [WN:0] ext;
  logic signed [WN:0] biased;
  logic signed [WN:0] scaled;
  logic signed [WN:0] hi_lim;
  logic signed [WN:0] lo_lim;

  assign ext    = (WN+1)'($signed(din));
  assign biased = ext + $signed(RND_INC);
  assign scaled = biased >>> DROP;
  assign hi_lim = $signed({{(WN+2-WO){1'b0}}, {(WO-1){1'b1}}});
  assign lo_lim = $signed({{(WN+2-WO){1'b1}}, {(WO-1){1'b0}}});
  assign ovf    = (scaled > hi_lim) || (scaled < lo_lim);

  // Clamp toward the bound matching the true sign, otherwise keep the low bits.
  always_comb begin
    dout = scaled[WO-1:0];
    if (SAT && ovf) begin
      dout = scaled[WN] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fxp_addsub_pipe.sv
// Two-stage signed fixed-point add/sub/load/accumulate with rounding, saturation and overflow flags.
// Latency: 2 cycles from input handshake to out_valid; 1 beat per cycle.
// Backpressure: whole pipe advances only when out is empty or taken; in_ready mirrors that enable.
module fxp_addsub_pipe
  import fxp_pkg::*;
#(
  parameter int WI1   = 8,
  parameter int WF1   = 8,
  parameter int WI2   = 8,
  parameter int WF2   = 8,
  parameter int WI0   = 8,
  parameter int WF0   = 8,
  parameter bit ROUND = 1'b1,
  parameter bit SAT   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WI1+WF1-1:0] in1,
  input  logic [WI2+WF2-1:0] in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WI0+WF0-1:0] out,
  output logic               ovf,
  output logic               ovf_sticky
);

  localparam int WIM = fxp_wim(WI1, WI2, WI0);
  localparam int WFM = fxp_wfm(WF1, WF2, WF0);
  localparam int WM  = WIM + WFM;
  localparam int W0  = WI0 + WF0;

  logic              en;
  logic signed [WM-1:0] a_al;
  logic signed [WM-1:0] b_al;
  logic signed [WM-1:0] acc_al;
  logic signed [WM-1:0] a_s1;
  logic signed [WM-1:0] b_s1;
  logic signed [WM-1:0] sum;
  logic              vld_s1;
  op_t               op_s1;
  logic [W0-1:0]     acc;
  logic [W0-1:0]     rs_out;
  logic              rs_ovf;
  logic              done;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign done     = en && vld_s1;

  // Sign-extend at the MSB, zero-pad at the LSB into the common internal format.
  assign a_al   = WM'($signed(in1)) <<< (WFM - WF1);
  assign b_al   = WM'($signed(in2)) <<< (WFM - WF2);
  assign acc_al = WM'($signed(acc)) <<< (WFM - WF0);

  // Stage 1: capture aligned operands and opcode whenever the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_s1 <= 1'b0;
      op_s1  <= OP_ADD;
      a_s1   <= '0;
      b_s1   <= '0;
    end else if (en) begin
      vld_s1 <= in_valid;
      op_s1  <= op_t'(op);
      a_s1   <= a_al;
      b_s1   <= b_al;
    end
  end

  // Full-width arithmetic; acc is read live so back-to-back ACC beats chain.
  always_comb begin
    sum = a_s1;
    case (op_s1)
      OP_ADD:  sum = a_s1 + b_s1;
      OP_SUB:  sum = a_s1 - b_s1;
      OP_LOAD: sum = a_s1;
      OP_ACC:  sum = acc_al + a_s1;
      default: sum = a_s1;
    endcase
  end

  fxp_round_sat #(
    .WII  (WIM),
    .WFI  (WFM),
    .WIO  (WI0),
    .WFO  (WF0),
    .ROUND(ROUND),
    .SAT  (SAT)
  ) u_round_sat (
    .din (sum),
    .dout(rs_out),
    .ovf (rs_ovf)
  );

  // Stage 2: output register; holds its value while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= vld_s1;
      if (vld_s1) begin
        out <= rs_out;
        ovf <= rs_ovf;
      end
    end
  end

  // Accumulator and sticky flag; clr wins over a same-edge LOAD/ACC write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else if (clr) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (done && (op_s1 == OP_LOAD || op_s1 == OP_ACC)) begin
        acc <= rs_out;
      end
      if (done && rs_ovf) begin
        ovf_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// Bench for fxp_addsub_pipe: three configurations driven in lockstep, checked against an arithmetic model.
// Latency: n/a.
// Backpressure: random and directed out_ready stalls.
module tb_fxp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  op = 2'd0;
  logic [15:0] in1 = '0;
  logic [15:0] in2 = '0;

  logic        rdy0, rdy1, rdy2;
  logic        vld0, vld1, vld2;
  logic        ovf0, ovf1, ovf2;
  logic        st0, st1, st2;
  logic [15:0] o0;
  logic [11:0] o1, o2;

  always #5 clk = ~clk;

  // d0: Q8.8 out, round+sat. d1: Q8.4 out, round+wrap. d2: Q8.4 out, truncate+sat.
  fxp_addsub_pipe #(.WF0(8), .ROUND(1'b1), .SAT(1'b1)) d0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
    .op(op), .in1(in1), .in2(in2), .out_valid(vld0), .out_ready(out_ready),
    .out(o0), .ovf(ovf0), .ovf_sticky(st0));
  fxp_addsub_pipe #(.WF0(4), .ROUND(1'b1), .SAT(1'b0)) d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
    .op(op), .in1(in1), .in2(in2), .out_valid(vld1), .out_ready(out_ready),
    .out(o1), .ovf(ovf1), .ovf_sticky(st1));
  fxp_addsub_pipe #(.WF0(4), .ROUND(1'b0), .SAT(1'b1)) d2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
    .op(op), .in1(in1), .in2(in2), .out_valid(vld2), .out_ready(out_ready),
    .out(o2), .ovf(ovf2), .ovf_sticky(st2));

  typedef struct packed {
    logic [2:0][15:0] o;
    logic [2:0]       v;
  } exp_t;

  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  logic [15:0] log0[$];
  logic [15:0] log1[$];
  logic [15:0] log2[$];
  logic [2:0]  es = '0;
  longint      macc[3] = '{0, 0, 0};
  int          cf_wf[3] = '{8, 4, 4};
  bit          cf_rnd[3] = '{1'b1, 1'b1, 1'b0};
  bit          cf_sat[3] = '{1'b1, 1'b0, 1'b1};
  bit          rnd_rdy = 1'b0;
  exp_t        me;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact arithmetic in units of 2^-8, then rescale, round, range-limit.
  task automatic ref_calc(input int c, input logic [1:0] opc, input logic [15:0] x1,
                          input logic [15:0] x2, output logic [15:0] o, output logic v);
    longint a, b, s, r, hi, lo, m;
    int wf, w0;
    a  = longint'($signed(x1));
    b  = longint'($signed(x2));
    wf = cf_wf[c];
    w0 = 8 + wf;
    hi = (longint'(1) << (w0 - 1)) - 1;
    lo = -(hi + 1);
    m  = longint'(1) << w0;
    case (opc)
      2'd0:    s = a + b;
      2'd1:    s = a - b;
      2'd2:    s = a;
      default: s = macc[c] * (longint'(1) << (8 - wf)) + a;
    endcase
    if (cf_rnd[c] && wf < 8) s = s + (longint'(1) << (8 - wf - 1));
    r = s >>> (8 - wf);
    v = (r > hi) || (r < lo);
    if (v) begin
      if (cf_sat[c]) r = (r > hi) ? hi : lo;
      else begin
        r = r & (m - 1);
        if (r > hi) r = r - m;
      end
    end
    if (opc >= 2'd2) macc[c] = r;
    o = 16'(r & (m - 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] opc, input logic [15:0] a, input logic [15:0] b);
    bit          took = 1'b0;
    exp_t        e;
    logic [15:0] lo_v;
    logic        lv;
    op = opc; in1 = a; in2 = b; in_valid = 1'b1;
    for (int n = 0; n < 100 && !took; n++) begin
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = rdy0;
      @(posedge clk);
      #1;
    end
    chk("accept", longint'(took), 1);
    if (took) begin
      for (int c = 0; c < 3; c++) begin
        ref_calc(c, opc, a, b, lo_v, lv);
        e.o[c] = lo_v;
        e.v[c] = lv;
      end
      q.push_back(e);
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 30 && q.size() != 0; n++) tick();
    chk("drained", longint'(q.size()), 0);
    tick();
  endtask

  task automatic clear_logs();
    log0.delete(); log1.delete(); log2.delete();
  endtask

  // Scoreboard: every accepted output beat is matched in order against the model.
  always @(negedge clk) begin
    if (rst_n && vld0 && out_ready) begin
      chk("beat_expected", longint'(q.size() != 0), 1);
      if (q.size() != 0) begin
        me = q.pop_front();
        chk("out_d0", o0, me.o[0]);
        chk("ovf_d0", ovf0, me.v[0]);
        chk("out_d1", o1, me.o[1]);
        chk("ovf_d1", ovf1, me.v[1]);
        chk("out_d2", o2, me.o[2]);
        chk("ovf_d2", ovf2, me.v[2]);
        es = es | me.v;
        chk("sticky", {st2, st1, st0}, es);
        chk("vld_agree", {vld2, vld1}, 2'b11);
        log0.push_back(o0);
        log1.push_back(16'(o1));
        log2.push_back(16'(o2));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [15:0] ra, rb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", o0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_sticky", st0, 0);
    chk("rst_vld", vld0, 0);
    chk("rst_in_ready", rdy0, 1);
    rst_n = 1'b1;
    tick();

    // Basic ADD with latency check: 1.5 + 2.25 = 3.75
    clear_logs();
    send(2'd0, 16'h0180, 16'h0240);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_not_yet", vld0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_valid", vld0, 1);
    chk("add_out", o0, 16'h03C0);
    chk("add_ovf", ovf0, 0);
    drain();

    // SUB to negative, then positive overflow
    clear_logs();
    send(2'd1, 16'h0100, 16'h0300);
    send(2'd0, 16'h7F00, 16'h0100);
    drain();
    chk("ovf_beats", longint'(log0.size()), 2);
    chk("sub_out", log0[0], 16'hFE00);
    chk("sat_out", log0[1], 16'h7FFF);
    chk("wrap_out", log1[1], 16'h0800);
    chk("sat_ovf", ovf0, 1);
    chk("sat_sticky", st0, 1);
    chk("wrap_sticky", st1, 1);

    // Rounding vs truncation when dropping 4 LSBs
    clear_logs();
    send(2'd0, 16'h0018, 16'h0000);
    drain();
    chk("rnd_beats", longint'(log1.size()), 1);
    chk("round_up", log1[0], 16'h0002);
    chk("truncate", log2[0], 16'h0001);

    // LOAD then back-to-back ACC
    clear_logs();
    send(2'd2, 16'h0100, 16'h5555);
    send(2'd3, 16'h0100, 16'h0000);
    send(2'd3, 16'h0100, 16'h0000);
    send(2'd3, 16'h0100, 16'h0000);
    drain();
    chk("acc_beats", longint'(log0.size()), 4);
    chk("acc_0", log0[0], 16'h0100);
    chk("acc_1", log0[1], 16'h0200);
    chk("acc_2", log0[2], 16'h0300);
    chk("acc_3", log0[3], 16'h0400);

    // clr zeroes acc and sticky
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 3; c++) macc[c] = 0;
    es = '0;
    @(negedge clk);
    chk("clr_sticky0", st0, 0);
    chk("clr_sticky1", st1, 0);
    @(posedge clk); #1;
    clear_logs();
    send(2'd3, 16'h0100, 16'h0000);
    drain();
    chk("clr_acc", log0[0], 16'h0100);

    // Back-pressure: stall three cycles mid-stream
    clear_logs();
    send(2'd0, 16'h0100, 16'h0011);
    send(2'd0, 16'h0200, 16'h0022);
    out_ready = 1'b0;
    op = 2'd0; in1 = 16'h0300; in2 = 16'h0033;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_in_ready", rdy0, 0);
      chk("stall_vld", vld0, 1);
      chk("stall_out", o0, 16'h0111);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(2'd0, 16'h0300, 16'h0033);
    send(2'd0, 16'h0400, 16'h0044);
    drain();
    chk("bp_beats", longint'(log0.size()), 4);
    chk("bp_0", log0[0], 16'h0111);
    chk("bp_1", log0[1], 16'h0222);
    chk("bp_2", log0[2], 16'h0333);
    chk("bp_3", log0[3], 16'h0444);

    // Randomised mix with random consumer stalls
    rnd_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
      rb  = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
      send(rop, ra, rb);
    end
    rnd_rdy = 1'b0;
    drain();

    // Reset with two beats in flight
    send(2'd0, 16'h0101, 16'h0202);
    send(2'd0, 16'h0303, 16'h0404);
    rst_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    for (int c = 0; c < 3; c++) macc[c] = 0;
    es = '0;
    @(negedge clk);
    chk("mid_rst_vld", vld0, 0);
    chk("mid_rst_out", o0, 0);
    chk("mid_rst_out1", o1, 0);
    chk("mid_rst_ovf", ovf0, 0);
    chk("mid_rst_sticky", st0, 0);
    chk("mid_rst_in_ready", rdy0, 1);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("post_rst_idle", vld0, 0);
      @(posedge clk); #1;
    end
    send(2'd0, 16'h0080, 16'h0080);
    drain();

    chk("queue_empty", longint'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
